regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the datapath: one synchronous write port, NUM_RD combinational read ports, an optional hardwired zero register, and a hardware scrub engine that clears the array one entry per cycle after reset or on request. The storage array has no reset, so it maps to RAM/LUTRAM. Reads are gated while the scrub runs. It replaces the fixed 32x32, two-read-port register bank feeding the A/B operand registers.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
- clear_req  in  1  single-cycle pulse that starts a full scrub
- busy  out  1  scrub in progress
- wr_drop  out  1  registered pulse: the previous cycle's write was rejected

## Operation

- FSM has two states: IDLE and SCRUB. Async reset forces SCRUB with idx = 0.
- SCRUB:
  - Each cycle writes 0 to entry idx, then increments idx.
  - Moves to IDLE on the edge that writes idx = DEPTH-1.
  - idx is ADDR_W wide and wraps to 0 on exit.
- IDLE -> SCRUB on clear_req = 1. clear_req while in SCRUB is ignored; it does not restart the scrub.
- busy = 1 in SCRUB, 0 in IDLE. busy is decoded from the state register.
- Write accept rules:
  - Committed on the rising edge when wr_en = 1, state = IDLE, clear_req = 0, and not (ZERO_REG = 1 and wr_addr = 0).
  - wr_en in SCRUB, or wr_en together with clear_req in IDLE, is rejected. wr_drop = 1 on the following cycle.
  - A write to address 0 with ZERO_REG = 1 is silently discarded. It does not raise wr_drop.
- Read rules, per port:
  - rd_data = 0 while busy.
  - rd_data = 0 for address 0 when ZERO_REG = 1.
  - Otherwise rd_data = array[rd_addr], or the bypass value (see Configuration).
- Multiple read ports may address the same entry; each port returns the same value.

## Timing

- Reset values: busy = 1, wr_drop = 0, state = SCRUB, idx = 0, rd_data = 0 (forced by busy). Array contents are undefined until the scrub completes.
- Scrub takes exactly DEPTH cycles after reset release or after the clear_req edge. busy falls on edge DEPTH.
- The first write can be accepted in the cycle after busy falls.
- Write latency: the value is visible on a non-bypassed read in the cycle after the accepting edge.
- Read latency: combinational from rd_addr, zero cycles.
- wr_drop is asserted for one cycle, one cycle after the rejected request.
- Reset asserted mid-scrub or mid-write: the FSM and idx restart immediately; no partial write completes after reset asserts.

## Configuration

- REGFILE_BYPASS_EN defined:
  - A read port whose address equals wr_addr, in a cycle where the write will be accepted, returns wr_data in that same cycle (write-through forwarding).
  - Forwarding never applies to address 0 when ZERO_REG = 1, and never applies while busy.
- REGFILE_BYPASS_EN undefined: the same-cycle read returns the old array value; the new value appears the next cycle.

## Structure

- Package regfile_pkg holds:
  - the state enum (IDLE, SCRUB)
  - the default DATA_W / ADDR_W / NUM_RD constants
  - a helper function that computes the write-accept condition
- Sub-module regfile_scrub_ctrl holds the FSM, idx counter, busy and the reject/wr_drop logic. It outputs scrub_we, scrub_addr and wr_accept.
- Top level contains the array, the write mux (scrub vs. user), the read ports and the bypass.

## Test plan

- Reset release, then wr_en at cycle 0: busy high for exactly 32 cycles; writes during that window raise wr_drop; all rd_data = 0 throughout.
- After scrub, write 0xDEADBEEF to r5 and read r5 on both ports next cycle: both ports return 0xDEADBEEF.
- Write 0x12345678 to r0 (ZERO_REG = 1), then read r0: returns 0; wr_drop stays 0.
- Same-cycle write 0xA5A5A5A5 to r7 while reading r7:
  - with REGFILE_BYPASS_EN, returns 0xA5A5A5A5 that cycle;
  - without it, returns the old value, then 0xA5A5A5A5 the next cycle.
- Fill r1..r31 with nonzero values, then pulse clear_req together with wr_en to r3:
  - the write is dropped (wr_drop = 1 next cycle);
  - busy stays high for 32 cycles;
  - afterwards every register reads 0.
- Assert reset at scrub cycle 10, release 3 cycles later: scrub restarts from idx 0 and takes a full 32 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default sizes and write-accept helper for regfile_mp
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // zero_hit: the write targets the hardwired zero entry and must vanish silently
  function automatic logic write_accept(input logic   wr_en,
                                        input state_t state,
                                        input logic   clear_req,
                                        input logic   zero_hit);
    return wr_en && (state == IDLE) && !clear_req && !zero_hit;
  endfunction

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// rtl/regfile_scrub_ctrl.sv - scrub FSM, scrub index, busy and write reject tracking
// Scrub runs after reset and on clear_req; rejected writes raise a registered wr_drop pulse.
module regfile_scrub_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              clear_req,
  output logic              busy,
  output logic              wr_drop,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              wr_accept
);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              zero_hit;

  assign zero_hit   = (ZERO_REG != 0) && (wr_addr == '0);
  assign busy       = (state == SCRUB);
  assign scrub_we   = (state == SCRUB);
  assign scrub_addr = idx;
  assign wr_accept  = write_accept(wr_en, state, clear_req, zero_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SCRUB;
      idx     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && ((state == SCRUB) || clear_req);
      if (state == IDLE) begin
        if (clear_req) begin
          state <= SCRUB;
          idx   <= '0;
        end
      end else begin
        // idx wraps back to 0 on the final entry, ready for the next scrub
        idx <= idx + ADDR_W'(1);
        if (&idx) state <= IDLE;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with scrub engine and zero register
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              scrub_we;
  logic [ADDR_W-1:0] scrub_addr;
  logic              wr_accept;

  regfile_scrub_ctrl #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .clear_req (clear_req),
    .busy      (busy),
    .wr_drop   (wr_drop),
    .scrub_we  (scrub_we),
    .scrub_addr(scrub_addr),
    .wr_accept (wr_accept)
  );

  // No reset on the array so it stays mappable to RAM; the scrub gives it a known state
  always_ff @(posedge clk) begin
    if (scrub_we) begin
      mem[scrub_addr] <= '0;
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero_hit;
    logic [DATA_W-1:0] val;

    assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);

    always_comb begin
      val = mem[addr];
      if (busy || zero_hit) begin
        val = '0;
      end
`ifdef REGFILE_BYPASS_EN
      // wr_accept already excludes busy and the zero register
      else if (wr_accept && (wr_addr == addr)) begin
        val = wr_data;
      end
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard-driven directed bench for regfile_mp
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        clear_req;
  logic        busy;
  logic        wr_drop;

  logic [63:0] sb[$];
  int          vectors     = 0;
  int          miscompares = 0;

  regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .clear_req(clear_req),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] fill(input int i);
    return (32'h0101_0101 * i) ^ 32'hC000_0000;
  endfunction

  task automatic push(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      return;
    end
    exp = sb.pop_front();
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    clear_req = 1'b0;
    repeat (3) cyc();

    // reset state
    push(64'd1); push(64'd0); push(64'd0);
    smp();
    chk("reset_busy", 64'(busy));
    chk("reset_wr_drop", 64'(wr_drop));
    chk("reset_rd", rd_data);
    cyc();

    // release reset with a write pending through the whole scrub window
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'h0BAD_F00D;
    rd_addr = {5'd9, 5'd5};
    for (int i = 0; i < 32; i++) begin
      push(64'd1); push(64'd0);
      if (i > 0) push(64'd1);
      smp();
      chk("scrub_busy", 64'(busy));
      chk("scrub_rd_zero", rd_data);
      if (i > 0) chk("scrub_wr_drop", 64'(wr_drop));
      cyc();
    end
    wr_en = 1'b0;
    push(64'd0); push(64'd1);
    smp();
    chk("scrub_done_busy", 64'(busy));
    chk("last_scrub_wr_drop", 64'(wr_drop));
    cyc();

    // write r5, read on both ports
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEAD_BEEF;
    rd_addr = {5'd5, 5'd5};
    push(64'd0);
`ifdef REGFILE_BYPASS_EN
    push({32'hDEAD_BEEF, 32'hDEAD_BEEF});
`else
    push(64'd0);
`endif
    smp();
    chk("idle_wr_drop", 64'(wr_drop));
    chk("r5_same_cycle", rd_data);
    cyc();
    wr_en = 1'b0;
    push({32'hDEAD_BEEF, 32'hDEAD_BEEF}); push(64'd0);
    smp();
    chk("r5_both_ports", rd_data);
    chk("r5_wr_drop", 64'(wr_drop));
    cyc();

    // write to the zero register
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'h1234_5678;
    rd_addr = {5'd0, 5'd0};
    push(64'd0);
    smp();
    chk("r0_same_cycle", rd_data);
    cyc();
    wr_en = 1'b0;
    push(64'd0); push(64'd0);
    smp();
    chk("r0_reads_zero", rd_data);
    chk("r0_no_wr_drop", 64'(wr_drop));
    cyc();

    // same-cycle write and read of r7
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h1111_1111;
    cyc();
    wr_data = 32'hA5A5_A5A5;
    rd_addr = {5'd5, 5'd7};
`ifdef REGFILE_BYPASS_EN
    push({32'hDEAD_BEEF, 32'hA5A5_A5A5});
`else
    push({32'hDEAD_BEEF, 32'h1111_1111});
`endif
    smp();
    chk("r7_same_cycle", rd_data);
    cyc();
    wr_en = 1'b0;
    push({32'hDEAD_BEEF, 32'hA5A5_A5A5});
    smp();
    chk("r7_next_cycle", rd_data);
    cyc();

    // fill r1..r31 and read back
    for (int i = 1; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = fill(i);
      cyc();
    end
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rd_addr = {5'(32 - i), 5'(i)};
      push({fill(32 - i), fill(i)});
      smp();
      chk("fill_readback", rd_data);
      cyc();
    end

    // clear_req together with a write
    rd_addr   = {5'd31, 5'd30};
    clear_req = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 32'hFFFF_FFFF;
    push(64'd0); push({fill(31), fill(30)});
    smp();
    chk("clear_cycle_busy", 64'(busy));
    chk("clear_cycle_rd", rd_data);
    cyc();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0) push(64'd1);
      push(64'd1); push(64'd0);
      smp();
      if (i == 0) chk("clear_wr_drop", 64'(wr_drop));
      chk("clear_busy", 64'(busy));
      chk("clear_rd_gated", rd_data);
      cyc();
    end
    push(64'd0); push(64'd0);
    smp();
    chk("clear_done_busy", 64'(busy));
    chk("clear_done_wr_drop", 64'(wr_drop));
    cyc();
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      push(64'd0);
      smp();
      chk("cleared_readback", rd_data);
      cyc();
    end

    // reset asserted at scrub cycle 10
    wr_en   = 1'b1;
    wr_addr = 5'd31;
    wr_data = 32'h3131_3131;
    cyc();
    wr_en     = 1'b0;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (10) cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(64'd1); push(64'd0);
      smp();
      chk("midreset_busy", 64'(busy));
      chk("midreset_wr_drop", 64'(wr_drop));
      cyc();
    end
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push(64'd1);
      smp();
      chk("rescrub_busy", 64'(busy));
      cyc();
    end
    rd_addr = {5'd31, 5'd9};
    push(64'd0); push(64'd0);
    smp();
    chk("rescrub_done_busy", 64'(busy));
    chk("rescrub_rd", rd_data);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
